// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT final-stage controllers.
// Bin/group geometry and the denorm scheduler state encoding.
package fft_pkg;

  localparam int N_POINTS  = 512;
  localparam int GRP_SIZE  = 16;
  localparam int NUM_GRP   = N_POINTS / GRP_SIZE;
  localparam int GRP_IDX_W = $clog2(NUM_GRP);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} denorm_state_t;

  // Group index advance; wraps only after the final group of a frame.
  function automatic logic [GRP_IDX_W-1:0] grp_next(input logic [GRP_IDX_W-1:0] idx);
    if (idx == GRP_IDX_W'(NUM_GRP - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/fft_lat_timer.sv
// Loadable down-counter with zero flag, shared by the FFT stage controllers.
// expire_o flags the decrement that takes the count from 1 to 0.
module fft_lat_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o   = (cnt_q == '0);
  assign expire_o = dec_i && !load_i && (cnt_q == W'(1));

endmodule

// File: rtl/fft_denorm_sched.sv
// Frame scheduler for the final FFT stage denormalization: launch, latency wait, group burst.
// Define FFT_DENORM_STALL_EN to add the out_ready backpressure port.
module fft_denorm_sched
  import fft_pkg::*;
#(
  parameter int PIPE_LAT = 25,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid_in,
  input  logic                 clear,
`ifdef FFT_DENORM_STALL_EN
  input  logic                 out_ready,
`endif
  output logic                 in_ready,
  output logic                 idx_load,
  output logic                 busy,
  output logic                 grp_en,
  output logic [GRP_IDX_W-1:0] grp_idx,
  output logic                 grp_last,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 overrun
);

  localparam logic [GRP_IDX_W-1:0] GRP_LAST = GRP_IDX_W'(NUM_GRP - 1);
  localparam logic [7:0]           LAT_LOAD = 8'(PIPE_LAT - 1);

  denorm_state_t        state_q, state_d;
  logic                 pend_q, pend_d;
  logic [GRP_IDX_W-1:0] grp_idx_q, grp_idx_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 idx_load_q, grp_en_q, busy_q, frame_done_q;
  logic                 rdy, xfer, launch, drop;
  logic                 tmr_zero, tmr_expire;

`ifdef FFT_DENORM_STALL_EN
  assign rdy = out_ready;
`else
  assign rdy = 1'b1;
`endif

  assign xfer = grp_en_q && rdy;

  fft_lat_timer #(
    .W(8)
  ) u_lat_timer (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (launch),
    .load_val_i(LAT_LOAD),
    .dec_i     (state_q == WAIT),
    .zero_o    (tmr_zero),
    .expire_o  (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    grp_idx_d = grp_idx_q;
    launch    = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: begin
        // A held frame goes first; a same-cycle valid_in takes its place.
        if (pend_q) begin
          launch = 1'b1;
          pend_d = valid_in;
        end else if (valid_in) begin
          launch = 1'b1;
        end
        if (launch) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tmr_expire || tmr_zero) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          grp_idx_d = grp_next(grp_idx_q);
          if (grp_idx_q == GRP_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && valid_in) begin
      if (!pend_q) begin
        pend_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Clear beats a completing frame; a drop beats clear.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (clear) begin
      frame_cnt_d = '0;
    end else if (state_q == DONE) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      grp_idx_q    <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      idx_load_q   <= 1'b0;
      grp_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      grp_idx_q    <= grp_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      idx_load_q   <= launch;
      grp_en_q     <= (state_d == BURST);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign in_ready   = ~pend_q;
  assign idx_load   = idx_load_q;
  assign busy       = busy_q;
  assign grp_en     = grp_en_q;
  assign grp_idx    = grp_idx_q;
  assign grp_last   = grp_en_q && (grp_idx_q == GRP_LAST);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_denorm_sched.sv
// Scoreboard bench for fft_denorm_sched: frame-level reference model feeds expected-event queues.
// Builds with or without FFT_DENORM_STALL_EN.
module tb_fft_denorm_sched;

  localparam int PIPE_LAT = 25;
  localparam int CNT_W    = 4;
  localparam int NBEAT    = 512 / 16;
  localparam int MAXC     = 9000;

  logic             clk = 1'b0;
  logic             rstn, valid_in, clear, out_ready;
  logic             in_ready, idx_load, busy, grp_en, grp_last, frame_done, overrun;
  logic [4:0]       grp_idx;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  fft_denorm_sched #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .clear     (clear),
`ifdef FFT_DENORM_STALL_EN
    .out_ready (out_ready),
`endif
    .in_ready  (in_ready),
    .idx_load  (idx_load),
    .busy      (busy),
    .grp_en    (grp_en),
    .grp_idx   (grp_idx),
    .grp_last  (grp_last),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .overrun   (overrun)
  );

  typedef struct { int cyc; int idx; } beat_t;

  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  bit    ready_pat [MAXC];
  beat_t q_beat [$];
  int    q_load [$];
  int    q_done [$];
  int    m_free, m_cnt;
  bit    m_pend, m_ov, prev_v, prev_cl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // A frame launched at the edge ending cycle p: idx_load next cycle, first beat
  // PIPE_LAT cycles later, one beat per ready cycle, done one cycle after the last beat.
  task automatic launch_frame(input int p);
    int    t;
    beat_t b;
    q_load.push_back(p + 1);
    t = p + PIPE_LAT;
    for (int k = 0; k < NBEAT; k++) begin
      while (t < MAXC - 1 && !ready_pat[t]) t++;
      b.cyc = t;
      b.idx = k;
      q_beat.push_back(b);
      t++;
    end
    q_done.push_back(t);
    m_free = t + 1;
  endtask

  task automatic model_step(input int p);
    bit done_p, drop;
    done_p = (m_free > 0) && (p == m_free - 1);
    drop   = 1'b0;
    if (p >= m_free) begin
      if (m_pend) begin
        launch_frame(p);
        m_pend = prev_v;
      end else if (prev_v) begin
        launch_frame(p);
      end
    end else if (prev_v) begin
      if (!m_pend) m_pend = 1'b1;
      else drop = 1'b1;
    end
    if (drop) m_ov = 1'b1;
    else if (prev_cl) m_ov = 1'b0;
    if (prev_cl) m_cnt = 0;
    else if (done_p) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic step(input bit v, input bit cl);
    @(posedge clk);
    #1;
    model_step(cyc - 1);
    valid_in  = v;
    clear     = cl;
    out_ready = (cyc < MAXC) ? ready_pat[cyc] : 1'b1;
    prev_v    = v;
    prev_cl   = cl;
  endtask

  // Monitor: status against the model every cycle, events popped as the DUT shows them.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("in_ready", in_ready, !m_pend);
      chk("busy", busy, (cyc < m_free));
      chk("overrun", overrun, m_ov);
      chk("frame_cnt", frame_cnt, m_cnt);

      if (q_beat.size() > 0 && q_beat[0].cyc < cyc) begin
        chk("beat_missed_at", cyc, q_beat[0].cyc);
        void'(q_beat.pop_front());
      end
      if (grp_en) begin
        if (q_beat.size() == 0) chk("beat_queue", q_beat.size(), 1);
        else if (out_ready) begin
          chk("beat_cycle", cyc, q_beat[0].cyc);
          chk("beat_idx", grp_idx, q_beat[0].idx);
          chk("beat_last", grp_last, (q_beat[0].idx == NBEAT - 1));
          void'(q_beat.pop_front());
        end else begin
          chk("stall_hold_idx", grp_idx, q_beat[0].idx);
        end
      end else begin
        chk("grp_last_quiet", grp_last, 1'b0);
      end

      if (q_load.size() > 0 && q_load[0] < cyc) begin
        chk("idx_load_missed_at", cyc, q_load[0]);
        void'(q_load.pop_front());
      end
      if (idx_load) begin
        if (q_load.size() == 0) chk("idx_load_queue", q_load.size(), 1);
        else begin
          chk("idx_load_cycle", cyc, q_load[0]);
          void'(q_load.pop_front());
        end
      end

      if (q_done.size() > 0 && q_done[0] < cyc) begin
        chk("frame_done_missed_at", cyc, q_done[0]);
        void'(q_done.pop_front());
      end
      if (frame_done) begin
        if (q_done.size() == 0) chk("frame_done_queue", q_done.size(), 1);
        else begin
          chk("frame_done_cycle", cyc, q_done[0]);
          void'(q_done.pop_front());
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || m_pend) && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("drain_idle", (busy || m_pend), 1'b0);
  endtask

  initial begin
    bit found;
    int d, n;
    for (int i = 0; i < MAXC; i++) begin
`ifdef FFT_DENORM_STALL_EN
      ready_pat[i] = ($urandom_range(3) != 0);
`else
      ready_pat[i] = 1'b1;
`endif
    end
    rstn = 1'b0; valid_in = 1'b0; clear = 1'b0; out_ready = 1'b1;
    prev_v = 1'b0; prev_cl = 1'b0;
    m_free = 0; m_cnt = 0; m_pend = 1'b0; m_ov = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    chk("reset_idx_load", idx_load, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_grp_en", grp_en, 1'b0);
    chk("reset_grp_idx", grp_idx, 0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_overrun", overrun, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    rstn = 1'b1;

    // Single frame launched from cycle 10.
    while (cyc < 9) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    while (cyc < 69) step(1'b0, 1'b0);
    drain(400);
    chk("single_frame_cnt", frame_cnt, 1);

    // Sparse random frames and clears.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(39) == 0), ($urandom_range(299) == 0));

    // Continuous valid_in: pend refill, drops, frame_cnt wrap.
    for (int i = 0; i < 1100; i++) step(1'b1, 1'b0);

    // clear on the frame_done cycle of the frame in flight.
    n = 0;
    while (!(m_free - 1 > cyc + 1) && n < 300) begin
      step(1'b0, 1'b0);
      n++;
    end
    d = m_free - 1;
    while (cyc < d - 1) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("clear_done_frame_done", frame_done, 1'b1);
    step(1'b0, 1'b0);
    chk("clear_done_frame_cnt", frame_cnt, 0);
    chk("clear_done_overrun", overrun, 1'b0);
    drain(400);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      #2;
      if (grp_en && grp_idx == 5'd12) found = 1'b1;
      else step(1'b0, 1'b0);
    end
    chk("abort_reached_idx12", found, 1'b1);
    rstn = 1'b0;
    #1;
    chk("abort_grp_en", grp_en, 1'b0);
    chk("abort_grp_idx", grp_idx, 0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_frame_cnt", frame_cnt, 0);
    q_beat.delete(); q_load.delete(); q_done.delete();
    m_free = 0; m_cnt = 0; m_pend = 1'b0; m_ov = 1'b0;
    prev_v = 1'b0; prev_cl = 1'b0;
    step(1'b0, 1'b0);
    rstn = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    drain(400);
    repeat (5) step(1'b0, 1'b0);
    chk("after_abort_frame_cnt", frame_cnt, 1);

    chk("beats_left", q_beat.size(), 0);
    chk("loads_left", q_load.size(), 0);
    chk("dones_left", q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
